// File: rtl/tpu_pkg.sv
// Shared definitions for the matrix datapath.
// The byte-wide memory loader and the result streamer both size themselves from these.
package tpu_pkg;

  localparam int DATA_W_DEFAULT  = 16;
  localparam int N_ELEMS_DEFAULT = 4;
  localparam int BYTES_PER_ELEM  = DATA_W_DEFAULT / 8;
  localparam int TOTAL_BYTES     = N_ELEMS_DEFAULT * BYTES_PER_ELEM;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_t;

endpackage

// File: rtl/result_streamer.sv
// Captures the result matrix from the compute array in a single cycle.
// It then streams the matrix out one byte per valid/ready handshake.
// Bytes go out in element order, and least-significant byte first within each element.
module result_streamer
  import tpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int N_ELEMS = N_ELEMS_DEFAULT,
  localparam int TOTAL  = N_ELEMS * DATA_W / 8,
  localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [N_ELEMS*DATA_W-1:0] results_i,
  output logic [7:0]                out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [IDX_W-1:0]          out_idx_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overrun_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  stream_state_t             state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [N_ELEMS*DATA_W-1:0] shadow_q, shadow_d;
  logic                      done_q, done_d;
  logic                      overrun_q, overrun_d;

  // State, byte counter, shadow copy and flags; a synchronous reset abandons any stream in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic: capture on load when idle, advance on handshake, and flag loads that arrive mid-stream.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          shadow_d = results_i;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (load_i) begin
          overrun_d = 1'b1;
        end
        if (out_ready_i) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come only from registers, so the pins see no combinational path from any input.
  always_comb begin
    busy_o      = (state_q == SEND);
    out_valid_o = (state_q == SEND);
    out_idx_o   = cnt_q;
    out_data_o  = (state_q == SEND) ? shadow_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    done_o      = done_q;
    overrun_o   = overrun_q;
  end

endmodule

// File: tb/tb_result_streamer.sv
// Directed testbench for result_streamer.
// Expected byte streams are hand-written from the input matrices.
module tb_result_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_i;
  logic [63:0] results_i;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  out_idx_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] basicExp [8];
  logic [7:0] onesExp  [8];
  logic [7:0] ffExp    [8];

  result_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_i),
    .results_i   (results_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_idx_o   (out_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst         = 1'b1;
    load_i      = 1'b0;
    out_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One-cycle load pulse; returns in the cycle the first byte should be presented.
  task automatic applyStimulus(input logic [63:0] res);
    results_i = res;
    load_i    = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  // Walks a stream byte by byte; mode 1 drives ready as 1,0,0 repeating; injectAt >= 0 pulses a load at that byte.
  task automatic runStream(input string tag, input logic [7:0] e [8], input int mode,
                           input int injectAt, input logic [63:0] injectVal);
    int idx = 0;
    int cyc = 0;
    bit injected = 1'b0;
    bit handshake;
    while (idx < 8 && cyc < 100) begin
      checkOutput({tag, "_valid"}, {31'b0, out_valid_o}, 32'd1);
      checkOutput({tag, "_idx"}, {29'b0, out_idx_o}, idx);
      checkOutput({tag, "_data"}, {24'b0, out_data_o}, {24'b0, e[idx]});
      out_ready_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (!injected && idx == injectAt) begin
        load_i    = 1'b1;
        results_i = injectVal;
        injected  = 1'b1;
      end else begin
        load_i = 1'b0;
      end
      handshake = out_ready_i;
      tick();
      if (handshake) idx++;
      cyc++;
    end
    load_i      = 1'b0;
    out_ready_i = 1'b1;
    checkOutput({tag, "_complete"}, idx, 32'd8);
    checkOutput({tag, "_done"}, {31'b0, done_o}, 32'd1);
    checkOutput({tag, "_busy_end"}, {31'b0, busy_o}, 32'd0);
    checkOutput({tag, "_valid_end"}, {31'b0, out_valid_o}, 32'd0);
  endtask

  initial begin
    int doneSeen;
    basicExp = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h7F};
    onesExp  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    ffExp    = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    rst         = 1'b1;
    load_i      = 1'b0;
    out_ready_i = 1'b0;
    results_i   = '0;

    doReset();
    checkOutput("rst_valid", {31'b0, out_valid_o}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'b0, done_o}, 32'd0);
    checkOutput("rst_overrun", {31'b0, overrun_o}, 32'd0);
    checkOutput("rst_idx", {29'b0, out_idx_o}, 32'd0);
    checkOutput("rst_data", {24'b0, out_data_o}, 32'd0);

    // Basic stream with ready held high.
    out_ready_i = 1'b1;
    applyStimulus(64'h7F01_0000_FFFE_1234);
    runStream("basic", basicExp, 0, -1, 64'h0);
    checkOutput("basic_overrun", {31'b0, overrun_o}, 32'd0);
    tick();
    checkOutput("basic_done_clear", {31'b0, done_o}, 32'd0);
    checkOutput("basic_busy_after", {31'b0, busy_o}, 32'd0);

    // Back-pressure with ready pattern 1,0,0.
    applyStimulus(64'h7F01_0000_FFFE_1234);
    runStream("bp", basicExp, 1, -1, 64'h0);
    tick();
    checkOutput("bp_done_clear", {31'b0, done_o}, 32'd0);

    // Overrun: a second load at byte 3 is ignored but flagged.
    applyStimulus(64'h0101_0101_0101_0101);
    runStream("ovr", onesExp, 0, 3, 64'hAAAA_AAAA_AAAA_AAAA);
    checkOutput("ovr_flag", {31'b0, overrun_o}, 32'd1);
    tick();
    checkOutput("ovr_sticky", {31'b0, overrun_o}, 32'd1);
    checkOutput("ovr_done_clear", {31'b0, done_o}, 32'd0);
    doReset();
    checkOutput("ovr_rst_clear", {31'b0, overrun_o}, 32'd0);

    // Back-to-back: a load in the done cycle starts a new stream.
    out_ready_i = 1'b1;
    applyStimulus(64'h7F01_0000_FFFE_1234);
    runStream("b2b_first", basicExp, 0, -1, 64'h0);
    applyStimulus(64'h00FF_00FF_00FF_00FF);
    runStream("b2b_second", ffExp, 0, -1, 64'h0);
    checkOutput("b2b_overrun", {31'b0, overrun_o}, 32'd0);
    tick();

    // Reset mid-stream at byte 5.
    applyStimulus(64'h7F01_0000_FFFE_1234);
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("mid_idx5", {29'b0, out_idx_o}, 32'd5);
    checkOutput("mid_data5", {24'b0, out_data_o}, 32'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_valid", {31'b0, out_valid_o}, 32'd0);
    checkOutput("mid_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("mid_idx", {29'b0, out_idx_o}, 32'd0);
    checkOutput("mid_data", {24'b0, out_data_o}, 32'd0);
    doneSeen = {31'b0, done_o};
    for (int i = 0; i < 10; i++) begin
      tick();
      doneSeen += {31'b0, done_o};
    end
    checkOutput("mid_no_done", doneSeen, 32'd0);
    applyStimulus(64'h00FF_00FF_00FF_00FF);
    runStream("mid_restart", ffExp, 0, -1, 64'h0);
    tick();

    // Ready with no load must not start anything.
    out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle_valid", {31'b0, out_valid_o}, 32'd0);
      checkOutput("idle_done", {31'b0, done_o}, 32'd0);
      checkOutput("idle_busy", {31'b0, busy_o}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
